// File: rtl/axi4lite_slave_mem_pkg.sv
// Shared AXI4-Lite definitions: bus geometry, response codes and the channel FSM state type.
package axi4lite_slave_mem_pkg;

  localparam int ADDRWIDTH   = 32;
  localparam int DATAWIDTH   = 32;
  localparam int MEMADDRBITS = 12;
  localparam int MEMSIZE     = 2**MEMADDRBITS;
  localparam int STRBWIDTH   = DATAWIDTH/8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_ADDR = 2'd1;
  localparam state_t S_DATA = 2'd2;
  localparam state_t S_RESP = 2'd3;

  function automatic resp_t resp_of(input logic in_range);
    return in_range ? OKAY : SLVERR;
  endfunction

endpackage

// File: rtl/axi4lite_mem_array.sv
// Word-organised memory: one byte-enabled write port, one registered read port, no reset.
module axi4lite_mem_array
  import axi4lite_slave_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   we,
  input  logic [STRBWIDTH-1:0]   wstrb,
  input  logic [MEMADDRBITS-1:0] waddr,
  input  logic [DATAWIDTH-1:0]   wdata,
  input  logic                   re,
  input  logic [MEMADDRBITS-1:0] raddr,
  output logic [DATAWIDTH-1:0]   rdata
);

  logic [DATAWIDTH-1:0] mem [MEMSIZE];

  // Read and write on the same edge: a read of the word being written sees the old value.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRBWIDTH; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite slave over on-chip memory: independent write and read FSMs, SLVERR outside the window.
//
// state  | meaning
// IDLE   | waiting for AWVALID / ARVALID
// ADDR   | AWREADY / ARREADY high for one cycle, address captured
// DATA   | write: WREADY high until WVALID; read: memory word registered
// RESP   | BVALID / RVALID high until BREADY / RREADY
module axi4lite_slave_mem
  import axi4lite_slave_mem_pkg::*;
(
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [ADDRWIDTH-1:0] AWADDR,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [DATAWIDTH-1:0] WDATA,
  input  logic [STRBWIDTH-1:0] WSTRB,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [1:0]           BRESP,
  output logic                 BVALID,
  input  logic                 BREADY,
  input  logic [ADDRWIDTH-1:0] ARADDR,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [DATAWIDTH-1:0] RDATA,
  output logic [1:0]           RRESP,
  output logic                 RVALID,
  input  logic                 RREADY
);

  state_t                 wr_state, rd_state;
  logic [MEMADDRBITS-1:0] wr_idx, rd_idx;
  logic                   wr_ok, rd_ok, rdata_ok;
  logic                   mem_we, mem_re;
  logic [DATAWIDTH-1:0]   mem_rdata;
  logic                   unused_addr_lsbs;

  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  assign mem_we = (wr_state == S_DATA) && WVALID && WREADY && wr_ok;
  assign mem_re = (rd_state == S_DATA);

  axi4lite_mem_array u_mem (
    .clk   (ACLK),
    .we    (mem_we),
    .wstrb (WSTRB),
    .waddr (wr_idx),
    .wdata (WDATA),
    .re    (mem_re),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state <= S_IDLE;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BRESP    <= OKAY;
      wr_idx   <= '0;
      wr_ok    <= 1'b0;
    end else begin
      case (wr_state)
        S_IDLE: if (AWVALID) begin
          AWREADY  <= 1'b1;
          wr_state <= S_ADDR;
        end
        S_ADDR: begin
          AWREADY  <= 1'b0;
          WREADY   <= 1'b1;
          wr_idx   <= AWADDR[MEMADDRBITS+1:2];
          wr_ok    <= (AWADDR[ADDRWIDTH-1:MEMADDRBITS+2] == '0);
          wr_state <= S_DATA;
        end
        S_DATA: if (WVALID) begin
          WREADY   <= 1'b0;
          BVALID   <= 1'b1;
          BRESP    <= resp_of(wr_ok);
          wr_state <= S_RESP;
        end
        S_RESP: if (BREADY) begin
          BVALID   <= 1'b0;
          wr_state <= S_IDLE;
        end
        default: wr_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state <= S_IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RRESP    <= OKAY;
      rd_idx   <= '0;
      rd_ok    <= 1'b0;
      rdata_ok <= 1'b0;
    end else begin
      case (rd_state)
        S_IDLE: if (ARVALID) begin
          ARREADY  <= 1'b1;
          rd_state <= S_ADDR;
        end
        S_ADDR: begin
          ARREADY  <= 1'b0;
          rd_idx   <= ARADDR[MEMADDRBITS+1:2];
          rd_ok    <= (ARADDR[ADDRWIDTH-1:MEMADDRBITS+2] == '0);
          rd_state <= S_DATA;
        end
        S_DATA: begin
          rdata_ok <= rd_ok;
          RRESP    <= resp_of(rd_ok);
          RVALID   <= 1'b1;
          rd_state <= S_RESP;
        end
        S_RESP: if (RREADY) begin
          RVALID   <= 1'b0;
          rd_state <= S_IDLE;
        end
        default: rd_state <= S_IDLE;
      endcase
    end
  end

  // The array's read register has no reset; a reset flop forces RDATA to zero until a good read.
  assign RDATA = rdata_ok ? mem_rdata : '0;

endmodule

// File: doc/axi4lite_slave_mem.md
# axi4lite_slave_mem

AXI4-Lite slave with a word-addressed on-chip memory. It sits directly downstream of the AXI4-Lite master and terminates its five channels. It services one write and one read transaction concurrently through two independent FSMs, using the shared IDLE/ADDR/DATA/RESP state type. Out-of-range accesses are answered with SLVERR and leave memory untouched.

## Interface
Parameters (all from the shared AXI4-Lite package):
- ADDRWIDTH, 32, bus address width
- DATAWIDTH, 32, bus data width
- MEMADDRBITS, 12, memory word-index bits
- MEMSIZE, 2**MEMADDRBITS, memory depth in words

Ports:
- ACLK  in  1  single clock; everything is rising-edge
- ARESETN  in  1  asynchronous, active-low reset
- AWADDR  in  ADDRWIDTH  write address
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATAWIDTH  write data
- WSTRB  in  DATAWIDTH/8  byte enables
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  ADDRWIDTH  read address
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATAWIDTH  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready

## Operation
- Address decode:
  - Word index = addr[MEMADDRBITS+1:2]; addr[1:0] is ignored.
  - In range when addr[ADDRWIDTH-1:MEMADDRBITS+2] == 0; otherwise the access is an error.
- Responses: OKAY = 2'b00 for in-range accesses, SLVERR = 2'b10 for errors.
- Write FSM:
  - IDLE: leave on AWVALID, go to ADDR.
  - ADDR: AWREADY=1 for exactly one cycle; capture AWADDR; go to DATA.
  - DATA: WREADY=1 until WVALID. On WVALID&&WREADY, if in range, write each byte lane i whose WSTRB[i]=1 and leave other bytes unchanged. Latch BRESP. Go to RESP.
  - RESP: BVALID=1 until BREADY is sampled high, then IDLE.
- Read FSM:
  - IDLE: leave on ARVALID, go to ADDR.
  - ADDR: ARREADY=1 for one cycle; capture ARADDR; go to DATA.
  - DATA: register mem[index] into RDATA (RDATA=0 on error). Latch RRESP. Go to RESP.
  - RESP: RVALID=1; RDATA and RRESP held stable until RREADY, then IDLE.
- WREADY is never asserted before the AW handshake, so the master must hold WVALID/WDATA.
- The two FSMs are fully independent. If a read's DATA cycle coincides with a write commit to the same word, the read returns the pre-write value.
- Memory is not reset; its contents are undefined until written.

## Timing
- Reset values, all asserted asynchronously:
  - Both FSMs go to IDLE.
  - AWREADY, WREADY, BVALID, ARREADY, RVALID = 0.
  - BRESP, RRESP = 2'b00; RDATA = 0.
- Write latency: AWVALID sampled at cycle 0, then AWREADY at 1, WREADY from 2, BVALID at (W handshake)+1.
- Read latency: ARVALID sampled at cycle 0, then ARREADY at 1, RVALID at 3.
- With BREADY/RREADY held high, each channel completes in 4 cycles and can start the next transaction from IDLE on the following cycle.
- All outputs are registered; there is no combinational input-to-output path.
- If reset asserts mid-transaction, that transaction is abandoned. A write already committed to memory stays; an uncommitted write is lost.

## Structure
- Shared package additions:
  - typedef enum logic [1:0] {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11} resp_t
  - STRBWIDTH = DATAWIDTH/8
  - Reuse the existing state enum for both FSMs.
- Sub-module axi4lite_mem_array: MEMSIZE x DATAWIDTH, one byte-enabled write port, one registered read port, no reset.
- The top level holds both FSMs, the address decode and the response registers.

## Test plan
- Reset: assert ARESETN=0 mid-cycle. All ready/valid outputs go to 0 immediately; BRESP=RRESP=0 and RDATA=0.
- Full-word write then read: write 0xDEADBEEF to address 0x10 with WSTRB=4'hF, then read 0x10. Expect BRESP=OKAY, RDATA=0xDEADBEEF, RRESP=OKAY, and the latencies given in Timing.
- Partial write: write 0x11223344 with WSTRB=4'b0101 over 0xDEADBEEF, then read. Expect RDATA=0xDE22BE44.
- Out of range: write to 0x0000_4000, then read 0x0000_4000. Expect BRESP=SLVERR, RRESP=SLVERR, RDATA=0, and word 0 unchanged.
- Backpressure: hold BREADY/RREADY low for 5 cycles. BVALID/RVALID, BRESP, RDATA and RRESP must stay stable; completion occurs the cycle after ready is sampled high.
- Concurrency: write 0xA5A5A5A5 to 0x20 while reading 0x20 (old value 0x0) with aligned timing. The read returns 0x0; a second read returns 0xA5A5A5A5.
